// File: rtl/reg_alu_pkg.sv
// reg_alu_pkg: opcode, select and EX-stage types shared by reg_alu_pipe and alu_w.
package reg_alu_pkg;
  localparam int DW_MAX = 64;
  localparam int AW_MAX = 8;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR} op_e;
  localparam logic SEL_LOAD = 1'b0;
  localparam logic SEL_ALU = 1'b1;
  // data fields are sized for the widest supported build; instances use the low WIDTH bits
  typedef struct packed {
    logic valid;
    logic sel;
    op_e op;
    logic [AW_MAX-1:0] wr_addr;
    logic [DW_MAX-1:0] a;
    logic [DW_MAX-1:0] b;
    logic [DW_MAX-1:0] d_in;
  } ex_stage_t;
endpackage

// File: rtl/alu_w.sv
// alu_w: combinational WIDTH-bit ALU producing a result and carry/borrow.
module alu_w
  import reg_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             cout
);
  localparam int SW = $clog2(WIDTH);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;
  logic [SW-1:0] sh;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  assign sh = b[SW-1:0];
  assign cout = op == OP_ADD ? sum[WIDTH] : op == OP_SUB ? dif[WIDTH] : 1'b0;
  always_comb begin
    case (op)
      OP_ADD:  res = sum[WIDTH-1:0];
      OP_SUB:  res = dif[WIDTH-1:0];
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      OP_SHL:  res = a << sh;
      OP_SHR:  res = a >> sh;
      default: res = '0;
    endcase
  end
endmodule

// File: rtl/reg_alu_pipe.sv
// reg_alu_pipe: two-stage (ID/EX) register-file + ALU pipeline with valid/ready issue.
// RAW_FORWARD_EN: bypass the EX result into ID instead of stalling one cycle on a RAW hazard.
module reg_alu_pipe
  import reg_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREG = 8,
  localparam int AW = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] d_in,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             cout,
  output logic             zero,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  ex_stage_t ex_q, ex_d;
  logic res_valid_q, res_valid_d, cout_q, cout_d, zero_q, zero_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [WIDTH-1:0] alu_res, wb_val, op_a, op_b;
  logic alu_cout, wb_cout, hit_a, hit_b, unused_ex;

  alu_w #(.WIDTH(WIDTH)) u_alu (
    .op(ex_q.op), .a(ex_q.a[WIDTH-1:0]), .b(ex_q.b[WIDTH-1:0]), .res(alu_res), .cout(alu_cout)
  );

  always_comb begin
    wb_val = ex_q.sel == SEL_ALU ? alu_res : ex_q.d_in[WIDTH-1:0];
    wb_cout = ex_q.sel == SEL_ALU && alu_cout;
    hit_a = ex_q.valid && ex_q.wr_addr[AW-1:0] == rd_addr_a;
    hit_b = ex_q.valid && ex_q.wr_addr[AW-1:0] == rd_addr_b;
`ifdef RAW_FORWARD_EN
    in_ready = !reset;
    op_a = hit_a ? wb_val : regs_q[rd_addr_a];
    op_b = hit_b ? wb_val : regs_q[rd_addr_b];
`else
    in_ready = !reset && !(in_valid && sel == SEL_ALU && (hit_a || hit_b));
    op_a = regs_q[rd_addr_a];
    op_b = regs_q[rd_addr_b];
`endif
    ex_d = '{valid: in_valid && in_ready, sel: sel, op: op_e'(op), wr_addr: AW_MAX'(wr_addr),
             a: DW_MAX'(op_a), b: DW_MAX'(op_b), d_in: DW_MAX'(d_in)};
    regs_d = regs_q;
    if (ex_q.valid) regs_d[ex_q.wr_addr[AW-1:0]] = wb_val;
    res_valid_d = ex_q.valid;
    res_data_d = ex_q.valid ? wb_val : res_data_q;
    cout_d = ex_q.valid ? wb_cout : cout_q;
    zero_d = ex_q.valid ? wb_val == '0 : zero_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
      ex_q <= '0;
      res_valid_q <= 1'b0;
      res_data_q <= '0;
      cout_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      ex_q <= ex_d;
      res_valid_q <= res_valid_d;
      res_data_q <= res_data_d;
      cout_q <= cout_d;
      zero_q <= zero_d;
    end
  end

  // upper struct bits beyond WIDTH/AW are constant zero
  assign unused_ex = ^ex_q;
  assign res_valid = res_valid_q;
  assign res_data = res_data_q;
  assign cout = cout_q;
  assign zero = zero_q;
  assign dbg_data = regs_q[dbg_addr];
endmodule

// File: tb/tb_reg_alu_pipe.sv
// tb_reg_alu_pipe: directed checks of reg_alu_pipe at 16 and 32 bits plus a modelled random stream.
module tb_reg_alu_pipe;
`ifdef RAW_FORWARD_EN
  localparam int STALL = 0;
`else
  localparam int STALL = 1;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v16 = 1'b0, v32 = 1'b0, sel_i = 1'b0;
  logic [2:0] op_i = '0;
  logic [3:0] ra_i = '0, rb_i = '0, wa_i = '0, dba32 = '0;
  logic [2:0] dba16 = '0;
  logic [31:0] d_i = '0;
  logic rdy16, rv16, c16, z16, rdy32, rv32, c32, z32;
  logic [15:0] rd16, dd16;
  logic [31:0] rd32, dd32;
  logic [33:0] q16[$];
  logic [33:0] q32[$];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_alu_pipe u16 (
    .clk(clk), .reset(rst), .in_valid(v16), .in_ready(rdy16), .sel(sel_i), .op(op_i),
    .rd_addr_a(ra_i[2:0]), .rd_addr_b(rb_i[2:0]), .wr_addr(wa_i[2:0]), .d_in(d_i[15:0]),
    .res_valid(rv16), .res_data(rd16), .cout(c16), .zero(z16), .dbg_addr(dba16), .dbg_data(dd16)
  );

  reg_alu_pipe #(.WIDTH(32), .NREG(16)) u32 (
    .clk(clk), .reset(rst), .in_valid(v32), .in_ready(rdy32), .sel(sel_i), .op(op_i),
    .rd_addr_a(ra_i), .rd_addr_b(rb_i), .wr_addr(wa_i), .d_in(d_i),
    .res_valid(rv32), .res_data(rd32), .cout(c32), .zero(z32), .dbg_addr(dba32), .dbg_data(dd32)
  );

  always @(negedge clk) begin
    if (rv16) q16.push_back({c16, z16, 16'h0, rd16});
    if (rv32) q32.push_back({c32, z32, rd32});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit tgt, input logic s, input logic [2:0] o, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [3:0] wa, input logic [31:0] d, output int st);
    sel_i = s; op_i = o; ra_i = ra; rb_i = rb; wa_i = wa; d_i = d;
    if (tgt) v32 = 1'b1; else v16 = 1'b1;
    st = 0;
    @(negedge clk);
    while (!(tgt ? rdy32 : rdy16) && st < 4) begin
      st++;
      @(negedge clk);
    end
    if (st >= 4) chk("ready_timeout", 64'(tgt ? rdy32 : rdy16), 1);
    @(posedge clk);
    #1;
    v16 = 1'b0;
    v32 = 1'b0;
  endtask

  task automatic ld(input bit tgt, input logic [3:0] wa, input logic [31:0] d);
    int st;
    issue(tgt, 1'b0, 3'd0, 4'd0, 4'd0, wa, d, st);
  endtask

  task automatic alu(input bit tgt, input logic [2:0] o, input logic [3:0] ra, input logic [3:0] rb,
                     input logic [3:0] wa, output int st);
    issue(tgt, 1'b1, o, ra, rb, wa, 32'd0, st);
  endtask

  task automatic res(input bit tgt, input string tag, input logic [31:0] d, input logic c, input logic z);
    logic [33:0] r;
    int n;
    n = tgt ? q32.size() : q16.size();
    chk({tag, "_valid"}, 64'(n > 0), 1);
    if (n > 0) begin
      if (tgt) r = q32.pop_front(); else r = q16.pop_front();
      chk({tag, "_data"}, 64'(r[31:0]), 64'(d));
      chk({tag, "_cout"}, 64'(r[33]), 64'(c));
      chk({tag, "_zero"}, 64'(r[32]), 64'(z));
    end
  endtask

  task automatic dbg16(input string tag, input logic [2:0] a, input logic [15:0] e);
    dba16 = a;
    #1;
    chk(tag, 64'(dd16), 64'(e));
  endtask

  function automatic logic [33:0] ref32(input logic s, input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] d);
    logic [32:0] t;
    logic [31:0] r;
    logic c;
    c = 1'b0;
    r = d;
    if (s) begin
      case (o)
        3'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[31:0]; c = t[32]; end
        3'd1: begin r = a - b; c = a < b; end
        3'd2: r = a & b;
        3'd3: r = a | b;
        3'd4: r = a ^ b;
        3'd5: r = ~a;
        3'd6: r = a << b[4:0];
        default: r = a >> b[4:0];
      endcase
    end
    return {c, r == 32'd0, r};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    int st;
    logic [2:0] o;
    logic [3:0] ra, rb, wa;
    logic s;
    logic [31:0] d;
    logic [33:0] e;
    logic [31:0] m [16];
    logic [33:0] exp_q[$];

    @(negedge clk);
    chk("rst_ready16", 64'(rdy16), 0);
    chk("rst_ready32", 64'(rdy32), 0);
    tick(2);
    rst = 1'b0;
    chk("rst_res_valid", 64'(rv16), 0);
    chk("rst_res_data", 64'(rd16), 0);
    chk("rst_cout", 64'(c16), 0);
    chk("rst_zero", 64'(z16), 0);
    dbg16("rst_r7", 3'd7, 16'h0);

    ld(0, 4'd1, 32'h5);
    ld(0, 4'd2, 32'h3);
    tick(3);
    res(0, "ld_r1", 32'h5, 1'b0, 1'b0);
    res(0, "ld_r2", 32'h3, 1'b0, 1'b0);
    chk("ld_extra", 64'(q16.size()), 0);
    dbg16("ld_dbg_r1", 3'd1, 16'h5);

    alu(0, 3'd0, 4'd1, 4'd2, 4'd3, st);
    chk("add_stall", 64'(st), 0);
    alu(0, 3'd1, 4'd3, 4'd2, 4'd4, st);
    chk("sub_raw_stall", 64'(st), 64'(STALL));
    tick(3);
    res(0, "add_chain", 32'h8, 1'b0, 1'b0);
    res(0, "sub_chain", 32'h5, 1'b0, 1'b0);
    chk("chain_extra", 64'(q16.size()), 0);
    dbg16("chain_r4", 3'd4, 16'h5);

    ld(0, 4'd5, 32'hFFFF);
    ld(0, 4'd6, 32'h1);
    alu(0, 3'd0, 4'd5, 4'd6, 4'd3, st);
    chk("carry_stall", 64'(st), 64'(STALL));
    alu(0, 3'd1, 4'd6, 4'd5, 4'd4, st);
    tick(3);
    res(0, "ld_r5", 32'hFFFF, 1'b0, 1'b0);
    res(0, "ld_r6", 32'h1, 1'b0, 1'b0);
    res(0, "add_carry", 32'h0, 1'b1, 1'b1);
    res(0, "sub_borrow", 32'h2, 1'b1, 1'b0);
    chk("carry_extra", 64'(q16.size()), 0);

    ld(0, 4'd7, 32'h8001);
    alu(0, 3'd6, 4'd7, 4'd6, 4'd0, st);
    chk("shl_stall", 64'(st), 64'(STALL));
    alu(0, 3'd7, 4'd7, 4'd6, 4'd1, st);
    chk("shr_stall", 64'(st), 0);
    alu(0, 3'd5, 4'd7, 4'd7, 4'd2, st);
    alu(0, 3'd4, 4'd7, 4'd7, 4'd3, st);
    alu(0, 3'd2, 4'd7, 4'd6, 4'd4, st);
    alu(0, 3'd3, 4'd7, 4'd6, 4'd5, st);
    tick(3);
    res(0, "ld_r7", 32'h8001, 1'b0, 1'b0);
    res(0, "shl", 32'h2, 1'b0, 1'b0);
    res(0, "shr", 32'h4000, 1'b0, 1'b0);
    res(0, "not", 32'h7FFE, 1'b0, 1'b0);
    res(0, "xor", 32'h0, 1'b0, 1'b1);
    res(0, "and", 32'h1, 1'b0, 1'b0);
    res(0, "or", 32'h8001, 1'b0, 1'b0);
    chk("logic_extra", 64'(q16.size()), 0);
    dbg16("shr_r1", 3'd1, 16'h4000);

    ld(0, 4'd2, 32'h1111);
    ld(0, 4'd2, 32'h2222);
    tick(3);
    res(0, "waw_1", 32'h1111, 1'b0, 1'b0);
    res(0, "waw_2", 32'h2222, 1'b0, 1'b0);
    dbg16("waw_r2", 3'd2, 16'h2222);

    ld(0, 4'd1, 32'hABCD);
    dbg16("lat_r1_early", 3'd1, 16'h4000);
    tick(1);
    dbg16("lat_r1", 3'd1, 16'hABCD);
    tick(2);
    res(0, "lat", 32'hABCD, 1'b0, 1'b0);
    chk("bubble_valid", 64'(rv16), 0);
    chk("bubble_data", 64'(rd16), 64'h0ABCD);
    chk("bubble_extra", 64'(q16.size()), 0);

    alu(0, 3'd0, 4'd1, 4'd1, 4'd0, st);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 64'(rdy16), 0);
    tick(1);
    rst = 1'b0;
    tick(2);
    chk("midrst_pulse", 64'(q16.size()), 0);
    chk("midrst_data", 64'(rd16), 0);
    dbg16("midrst_r0", 3'd0, 16'h0);
    dbg16("midrst_r1", 3'd1, 16'h0);

    ld(1, 4'd15, 32'hFFFF_FFFF);
    alu(1, 3'd0, 4'd15, 4'd15, 4'd14, st);
    chk("w32_stall", 64'(st), 64'(STALL));
    tick(3);
    res(1, "w32_ld", 32'hFFFF_FFFF, 1'b0, 1'b0);
    res(1, "w32_add", 32'hFFFF_FFFE, 1'b1, 1'b0);
    chk("w32_extra", 64'(q32.size()), 0);

    for (int i = 0; i < 16; i++) m[i] = 32'h0;
    m[15] = 32'hFFFF_FFFF;
    m[14] = 32'hFFFF_FFFE;
    for (int k = 0; k < 10000; k++) begin
      s = $urandom_range(0, 3) != 0;
      o = 3'($urandom_range(0, 7));
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      wa = 4'($urandom_range(0, 15));
      d = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : $urandom;
      e = ref32(s, o, m[ra], m[rb], d);
      exp_q.push_back(e);
      m[wa] = e[31:0];
      issue(1, s, o, ra, rb, wa, d, st);
    end
    tick(3);
    chk("rnd_count", 64'(q32.size()), 64'(exp_q.size()));
    while (q32.size() > 0 && exp_q.size() > 0) chk("rnd_res", 64'(q32.pop_front()), 64'(exp_q.pop_front()));
    for (int i = 0; i < 16; i++) begin
      dba32 = 4'(i);
      #1;
      chk("rnd_reg", 64'(dd32), 64'(m[i]));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
